// File: rtl/dz_pkg.sv
// Shared types, glyph table and row-strobe helpers for the dot-matrix scan decoder.
package dz_pkg;

   localparam int         NUM_W    = 3;
   localparam logic [7:0] ROW_IDLE = 8'hFF;

   // frame[i] holds the column byte for row i
   typedef logic [7:0][7:0] frame_t;

   typedef enum logic {
      ST_HUNT     = 1'b0,
      ST_ASSEMBLE = 1'b1
   } state_e;

   // Red glyphs by digit; written row 7 down to row 0 (MSB byte = row 7)
   localparam frame_t GLYPH_R [8] = '{
      64'h0000_0000_0000_0000,
      64'h0000_3C20_203C_0000,
      64'h0000_3C04_043C_0000,
      64'h0000_2424_243C_0000,
      64'h0000_003C_2424_2400,
      64'h0000_0000_0000_0000,
      64'h0000_0000_0000_0000,
      64'h0000_0000_0000_0000
   };
   localparam logic [7:0] GLYPH_VALID = 8'b0001_1111;

   function automatic logic row_legal(input logic [7:0] r);
      return ($countones(~r) == 1);
   endfunction

   function automatic logic [2:0] row_index(input logic [7:0] r);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (!r[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/dz_glyph_match.sv
// Combinational comparison of an assembled frame against the digit glyph table.
module dz_glyph_match
   import dz_pkg::*;
(
   input  frame_t           frame_r,
   input  frame_t           frame_g,
   input  logic             check_green,
   output logic             hit,
   output logic [NUM_W-1:0] code
);

   logic green_ok;

   always_comb begin
      hit      = 1'b0;
      code     = '0;
      green_ok = !check_green || (frame_g == '0);
      for (int d = 0; d < 8; d++) begin
         if (GLYPH_VALID[d] && green_ok && (frame_r == GLYPH_R[d])) begin
            hit  = 1'b1;
            code = NUM_W'(d);
         end
      end
   end

endmodule

// File: rtl/dz_scan_decode.sv
// Rebuilds 8-row frames from the active-low row strobe, matches them to digit
// glyphs and publishes a digit once it has been seen on consecutive frames.
module dz_scan_decode
   import dz_pkg::*;
#(
   parameter int STABLE_FRAMES = 2,
   parameter bit CHECK_GREEN   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       row,
   input  logic [7:0]       colr,
   input  logic [7:0]       colg,
   output logic [NUM_W-1:0] num_out,
   output logic             num_valid,
   output logic             frame_ok,
   output logic             unknown,
   output logic             sync_err,
   output logic             seq_err,
   output logic             dbg_state_o
);

   localparam logic [3:0] STABLE_C = 4'(STABLE_FRAMES);

   state_e           state_q, state_d;
   logic [2:0]       exp_q, exp_d, idx;
   frame_t           buf_r_q, buf_r_d, buf_g_q, buf_g_d, shad_r_q, shad_g_q;
   logic             done_q, done_d, sync_q, sync_d, seq_q, seq_d;
   logic             hit, mvld_q, mhit_q, frame_ok_q, unknown_q;
   logic [NUM_W-1:0] code, mcode_q, cand_q, cand_d, num_q;
   logic [3:0]       cnt_q, cnt_d;
   logic             locked_q, load, num_valid_q;

   assign idx = row_index(row);

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      buf_r_d = buf_r_q;
      buf_g_d = buf_g_q;
      done_d  = 1'b0;
      sync_d  = 1'b0;
      seq_d   = 1'b0;
      if (row != ROW_IDLE) begin
         if (!row_legal(row)) begin
            sync_d  = 1'b1;
            state_d = ST_HUNT;
         end else begin
            case (state_q)
               ST_HUNT: begin
                  if (idx == 3'd0) begin
                     buf_r_d[0] = colr;
                     buf_g_d[0] = colg;
                     exp_d      = 3'd1;
                     state_d    = ST_ASSEMBLE;
                  end
               end
               default: begin
                  if (idx == exp_q) begin
                     buf_r_d[idx] = colr;
                     buf_g_d[idx] = colg;
                     exp_d        = idx + 3'd1;  // wraps to 0 after row 7
                     done_d       = (idx == 3'd7);
                  end else begin
                     seq_d = 1'b1;
                     if (idx == 3'd0) begin
                        buf_r_d[0] = colr;
                        buf_g_d[0] = colg;
                        exp_d      = 3'd1;
                     end else begin
                        state_d = ST_HUNT;
                     end
                  end
               end
            endcase
         end
      end
   end

   dz_glyph_match u_match (
      .frame_r     (shad_r_q),
      .frame_g     (shad_g_q),
      .check_green (CHECK_GREEN),
      .hit         (hit),
      .code        (code)
   );

   // A miss breaks the run, so a following hit always restarts at 1
   always_comb begin
      cnt_d  = cnt_q;
      cand_d = cand_q;
      load   = 1'b0;
      if (mvld_q) begin
         if (mhit_q) begin
            if ((cnt_q != 4'd0) && (mcode_q == cand_q)) begin
               cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1;
            end else begin
               cnt_d  = 4'd1;
               cand_d = mcode_q;
            end
            load = (cnt_d == STABLE_C) && (!locked_q || (cand_d != num_q));
         end else begin
            cnt_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_HUNT;
         exp_q    <= '0;
         buf_r_q  <= '0;
         buf_g_q  <= '0;
         shad_r_q <= '0;
         shad_g_q <= '0;
         done_q   <= 1'b0;
         sync_q   <= 1'b0;
         seq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         buf_r_q <= buf_r_d;
         buf_g_q <= buf_g_d;
         done_q  <= done_d;
         sync_q  <= sync_d;
         seq_q   <= seq_d;
         if (done_d) begin
            shad_r_q <= buf_r_d;
            shad_g_q <= buf_g_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mvld_q      <= 1'b0;
         mhit_q      <= 1'b0;
         mcode_q     <= '0;
         frame_ok_q  <= 1'b0;
         unknown_q   <= 1'b0;
         cnt_q       <= '0;
         cand_q      <= '0;
         num_q       <= '0;
         locked_q    <= 1'b0;
         num_valid_q <= 1'b0;
      end else begin
         mvld_q      <= done_q;
         unknown_q   <= done_q && !hit;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         num_valid_q <= load;
         if (done_q) begin
            mhit_q     <= hit;
            mcode_q    <= code;
            frame_ok_q <= hit;
         end
         if (load) begin
            num_q    <= cand_d;
            locked_q <= 1'b1;
         end
      end
   end

   assign num_out     = num_q;
   assign num_valid   = num_valid_q;
   assign frame_ok    = frame_ok_q;
   assign unknown     = unknown_q;
   assign sync_err    = sync_q;
   assign seq_err     = seq_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dz_scan_decode.sv
// Directed and randomized scan streams checked cycle by cycle against a
// frame-level reference model of the decoder.
module tb_dz_scan_decode;

   localparam int STABLE = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] row, colr, colg;
   logic [2:0] num_out;
   logic       num_valid, frame_ok, unknown, sync_err, seq_err, dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   // reference model state
   bit hunting;
   int nxt;
   int fr_r [8];
   int fr_g [8];
   bit p1_v, p1_hit, p2_v, p2_hit;
   int p1_code, p2_code;
   int run_code, run_len;
   bit locked;
   int e_num;
   bit e_nv, e_fok, e_unk, e_sync, e_seq;

   always #5 clk = ~clk;

   dz_scan_decode #(.STABLE_FRAMES(STABLE), .CHECK_GREEN(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .row         (row),
      .colr        (colr),
      .colg        (colg),
      .num_out     (num_out),
      .num_valid   (num_valid),
      .frame_ok    (frame_ok),
      .unknown     (unknown),
      .sync_err    (sync_err),
      .seq_err     (seq_err),
      .dbg_state_o (dbg_state)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of run, expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int glyph_row(input int d, input int r);
      case (d)
         4: return (r >= 1 && r <= 3) ? 'h24 : ((r == 4) ? 'h3C : 0);
         3: return (r == 2) ? 'h3C : ((r >= 3 && r <= 5) ? 'h24 : 0);
         2: return (r == 2 || r == 5) ? 'h3C : ((r == 3 || r == 4) ? 'h04 : 0);
         1: return (r == 2 || r == 5) ? 'h3C : ((r == 3 || r == 4) ? 'h20 : 0);
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      hunting = 1'b1;  nxt = 0;
      p1_v = 1'b0;  p2_v = 1'b0;  p1_hit = 1'b0;  p2_hit = 1'b0;
      p1_code = 0;  p2_code = 0;
      run_code = 0;  run_len = 0;  locked = 1'b0;
      e_num = 0;  e_nv = 1'b0;  e_fok = 1'b0;  e_unk = 1'b0;
      e_sync = 1'b0;  e_seq = 1'b0;
   endtask

   task automatic ref_match(output bit hit, output int code);
      bit green_ok, same;
      hit = 1'b0;  code = 0;  green_ok = 1'b1;
      for (int r = 0; r < 8; r++) if (fr_g[r] != 0) green_ok = 1'b0;
      for (int d = 0; d <= 4; d++) begin
         same = 1'b1;
         for (int r = 0; r < 8; r++) if (fr_r[r] != glyph_row(d, r)) same = 1'b0;
         if (same && green_ok) begin
            hit = 1'b1;  code = d;
         end
      end
   endtask

   // Expected outputs right after one rising edge that sampled rw/cr/cg
   task automatic model_edge(input logic [7:0] rw, input logic [7:0] cr, input logic [7:0] cg);
      int zeros, idx, dc;
      bit dn, dh;
      zeros = 0;  idx = -1;  dn = 1'b0;  dh = 1'b0;  dc = 0;
      for (int i = 0; i < 8; i++) if (!rw[i]) begin zeros++; idx = i; end
      e_sync = 1'b0;  e_seq = 1'b0;
      if (rw != 8'hFF) begin
         if (zeros != 1) begin
            e_sync = 1'b1;  hunting = 1'b1;
         end else if (hunting) begin
            if (idx == 0) begin
               fr_r[0] = cr;  fr_g[0] = cg;  nxt = 1;  hunting = 1'b0;
            end
         end else if (idx == nxt) begin
            fr_r[idx] = cr;  fr_g[idx] = cg;
            if (idx == 7) begin
               dn = 1'b1;  ref_match(dh, dc);  nxt = 0;
            end else nxt = idx + 1;
         end else begin
            e_seq = 1'b1;
            if (idx == 0) begin
               fr_r[0] = cr;  fr_g[0] = cg;  nxt = 1;
            end else hunting = 1'b1;
         end
      end
      e_unk = p1_v && !p1_hit;
      if (p1_v) e_fok = p1_hit;
      e_nv = 1'b0;
      if (p2_v) begin
         if (p2_hit) begin
            if (run_len > 0 && p2_code == run_code) run_len++;
            else begin run_code = p2_code; run_len = 1; end
            if (run_len >= STABLE && (!locked || run_code != e_num)) begin
               e_num = run_code;  e_nv = 1'b1;  locked = 1'b1;
            end
         end else run_len = 0;
      end
      p2_v = p1_v;  p2_hit = p1_hit;  p2_code = p1_code;
      p1_v = dn;    p1_hit = dh;      p1_code = dc;
   endtask

   task automatic check_outputs();
      chk("num_out",   {5'b0, num_out},   8'(e_num));
      chk("num_valid", {7'b0, num_valid}, {7'b0, e_nv});
      chk("frame_ok",  {7'b0, frame_ok},  {7'b0, e_fok});
      chk("unknown",   {7'b0, unknown},   {7'b0, e_unk});
      chk("sync_err",  {7'b0, sync_err},  {7'b0, e_sync});
      chk("seq_err",   {7'b0, seq_err},   {7'b0, e_seq});
   endtask

   task automatic step(input logic [7:0] rw, input logic [7:0] cr, input logic [7:0] cg);
      @(negedge clk);
      row = rw;  colr = cr;  colg = cg;
      @(posedge clk);
      model_edge(rw, cr, cg);
      #2;
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) step(8'hFF, 8'h00, 8'h00);
   endtask

   function automatic logic [7:0] strobe(input int i);
      logic [7:0] s;
      s = 8'h01 << i;
      return ~s;
   endfunction

   task automatic send_rows(input int d, input int first, input int last);
      for (int i = first; i <= last; i++) step(strobe(i), 8'(glyph_row(d, i)), 8'h00);
   endtask

   task automatic send_frame(input int d, input int bad_row, input logic [7:0] bad_xor,
                             input int green_row, input logic [7:0] green_val, input bit gaps);
      logic [7:0] r, g;
      for (int i = 0; i < 8; i++) begin
         if (gaps && $urandom_range(0, 5) == 0) step(8'hFF, 8'($urandom), 8'($urandom));
         r = 8'(glyph_row(d, i));
         if (i == bad_row) r = r ^ bad_xor;
         g = (i == green_row) ? green_val : 8'h00;
         step(strobe(i), r, g);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_num"},  {5'b0, num_out},   8'h00);
      chk({tag, "_nv"},   {7'b0, num_valid}, 8'h00);
      chk({tag, "_fok"},  {7'b0, frame_ok},  8'h00);
      chk({tag, "_unk"},  {7'b0, unknown},   8'h00);
      chk({tag, "_sync"}, {7'b0, sync_err},  8'h00);
      chk({tag, "_seq"},  {7'b0, seq_err},   8'h00);
   endtask

   initial begin
      int cur, bad_row, green_row;
      rst = 1'b1;  row = 8'hFF;  colr = 8'h00;  colg = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // glyph 4 three times: lock on frame 2, no second pulse
      repeat (3) send_frame(4, -1, 8'h00, -1, 8'h00, 1'b0);
      idle(2);
      chk("t1_num", {5'b0, num_out}, 8'h04);

      // a single different glyph must not disturb the locked digit
      send_frame(4, -1, 8'h00, -1, 8'h00, 1'b0);
      send_frame(2, -1, 8'h00, -1, 8'h00, 1'b0);
      send_frame(4, -1, 8'h00, -1, 8'h00, 1'b0);
      idle(3);
      chk("t2_num", {5'b0, num_out}, 8'h04);

      // out-of-order row, then two clean glyph-3 frames
      send_rows(3, 0, 2);
      step(strobe(4), 8'(glyph_row(3, 4)), 8'h00);
      send_frame(3, -1, 8'h00, -1, 8'h00, 1'b0);
      send_frame(3, -1, 8'h00, -1, 8'h00, 1'b0);
      idle(2);
      chk("t3_num", {5'b0, num_out}, 8'h03);

      // illegal strobe mid-frame; trailing rows ignored until next row 0
      send_rows(4, 0, 3);
      step(8'b1111_1100, 8'h24, 8'h00);
      send_rows(4, 5, 7);
      send_frame(4, -1, 8'h00, -1, 8'h00, 1'b0);
      send_frame(4, -1, 8'h00, -1, 8'h00, 1'b0);
      idle(2);
      chk("t4_num", {5'b0, num_out}, 8'h04);

      // corrupted red pixel, then stray green pixel
      send_frame(3, 5, 8'h01, -1, 8'h00, 1'b0);
      idle(2);
      chk("t5_fok", {7'b0, frame_ok}, 8'h00);
      send_frame(3, -1, 8'h00, 0, 8'h01, 1'b0);
      idle(2);
      chk("t5_num", {5'b0, num_out}, 8'h04);

      // asynchronous reset in the middle of a glyph-1 frame
      send_rows(1, 0, 3);
      @(negedge clk);
      row = strobe(4);  colr = 8'h20;  colg = 8'h00;
      #2 rst = 1'b1;
      #1;
      check_all_zero("t6_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;  row = 8'hFF;
      send_frame(0, -1, 8'h00, -1, 8'h00, 1'b0);
      send_frame(0, -1, 8'h00, -1, 8'h00, 1'b0);
      idle(2);
      chk("t6_num", {5'b0, num_out}, 8'h00);

      // randomized stream: runs of digits, corruptions, gaps and glitches
      cur = 0;
      for (int f = 0; f < 250; f++) begin
         if ($urandom_range(0, 2) == 0) cur = $urandom_range(0, 4);
         bad_row   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1;
         green_row = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
         if ($urandom_range(0, 9) == 0) step(8'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 11) == 0) send_rows(cur, 0, $urandom_range(0, 6));
         send_frame(cur, bad_row, 8'($urandom_range(1, 255)), green_row,
                    8'($urandom_range(1, 255)), 1'b1);
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
